dvi_i2c_target: RTL
===================

Name: dvi_i2c_target

Overview:
- I2C target (responder) for the DVI transmitter configuration bus: the far end of the I2C master that programs the DVI encoder at power-up.
- Emulates the encoder's register file, for on-board loopback and the configuration-sequence test bench.
- Samples open-drain SCL/SDA and drives SDA low only through SDA_oe.
- Logs every write on a strobe port and exposes the register array on a side read port.

Parameters:
- DEV_ADDR, 7'h76, 7-bit target address this block responds to.
- NREGS, 64, number of implemented 8-bit registers; valid addresses are 0..NREGS-1, NREGS ≤ 256.

Ports:
- Clk  in  1  system clock; must be ≥ 16x SCL frequency.
- Reset_n  in  1  asynchronous active-low reset.
- SCL  in  1  bus clock as seen at the pad (pulled-up value).
- SDA_in  in  1  bus data as seen at the pad.
- SDA_oe  out  1  1 = pull SDA low; pad logic converts it to tristate.
- busy  out  1  high from START until STOP.
- reg_wr_stb  out  1  one-Clk pulse per stored data byte.
- reg_wr_addr  out  8  register address of the stored byte.
- reg_wr_data  out  8  stored byte.
- dbg_addr  in  8  side read address.
- dbg_data  out  8  combinational register contents at dbg_addr; 8'hFF if dbg_addr ≥ NREGS.

Behaviour:
- Reset: SDA_oe=0, busy=0, reg_wr_stb=0, reg_wr_addr=0, reg_wr_data=0, pointer=0, all registers=0, state IDLE.
- Input conditioning:
  - SCL and SDA_in each pass through a 2-FF synchronizer plus one history flop.
  - rise/fall = history mismatch; detection latency is 3 Clk.
- Bus events (on synchronized signals):
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Bit sampling on SCL rise.
  - SDA_oe updates on the Clk after a detected SCL fall.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- IDLE: START -> ADDR, busy=1, bit counter=0.
- ADDR: shift 8 bits MSB first.
  - Upper 7 bits = DEV_ADDR -> ADDR_ACK.
  - Otherwise -> IGNORE (no ACK driven).
- ADDR_ACK: SDA_oe=1 for the whole 9th clock, released on the following SCL fall.
  - R/W=0 -> REG.
  - R/W=1 -> RDATA; load the byte at pointer and drive its MSB on that same fall.
- REG: shift 8 bits into pointer, then REG_ACK (ACK always) -> WDATA.
- WDATA: shift 8 bits, then WDATA_ACK (ACK always).
  - If pointer < NREGS: register[pointer] updated and reg_wr_stb pulsed with pointer/byte on the SCL rise sampling bit 0.
  - Else: byte discarded, no strobe.
  - Pointer increments after the ACK.
  - -> WDATA.
- RDATA: SDA_oe = ~bit for each bit, changed only after SCL fall. Out-of-range pointer reads 8'hFF.
  - After 8 bits SDA_oe=0 -> RACK.
- RACK: sample master ACK on SCL rise; pointer increments.
  - ACK (0) -> RDATA with next byte.
  - NACK (1) -> IGNORE.
- IGNORE: SDA_oe=0; wait for START or STOP.
- Pointer arithmetic: 8-bit, wraps 8'hFF -> 8'h00.
- STOP in any state -> IDLE, SDA_oe=0, busy=0 within 1 Clk of detection. A partial byte is discarded.
- START while busy (repeated start):
  - -> ADDR, bit counter cleared, SDA_oe=0.
  - Pointer retained, so write-register-then-read works.
- START and STOP are never both detected on the same Clk (SDA cannot rise and fall together). The SCL edge takes precedence only when SDA is stable.
- Reset_n low mid-transfer: immediate return to reset values; SDA released asynchronously.

Test Plan:
- Write 0x76<<1|0, reg 0x21, data 0x09 -> three ACKs; one reg_wr_stb with addr 0x21, data 0x09; dbg_addr=0x21 gives 0x09.
- Burst write reg 0x3E, data 0xA1,0xB2,0xC3 -> strobes at 0x3E, 0x3F; 0x40 ≥ NREGS so no strobe, but still ACKed; dbg of 0x3F = 0xB2.
- Write pointer 0x21, repeated START, read 2 bytes (ACK then NACK) -> SDA carries 0x09 then contents of 0x22 (0x00); SDA released after NACK; busy=0 after STOP.
- Address 0x50 write -> no ACK (SDA_oe stays 0 for all 9 clocks); no strobes until next START.
- STOP after 4 data bits -> no strobe, IDLE, busy=0; a following valid write succeeds.
- Reset_n pulsed low during RDATA while SDA_oe=1 -> SDA_oe=0 immediately, registers cleared, dbg_data=0x00.

Source files
------------

// File: rtl/dvi_i2c_target.sv
//-----------------------------------------------------------------------------
// dvi_i2c_target
// I2C target that emulates the DVI encoder's configuration register file.
// It sits at the far end of the power-up configuration master. It serves the
// on-board loopback and the configuration-sequence bench.
//
// Ports
//   Clk          system clock, at least 16x the SCL frequency
//   Reset_n      asynchronous active-low reset
//   SCL          bus clock as seen at the pad
//   SDA_in       bus data as seen at the pad
//   SDA_oe       1 = pull SDA low (the pad converts this to a tristate)
//   busy         high from START until STOP
//   reg_wr_stb   one-Clk pulse for each stored data byte
//   reg_wr_addr  register address of the stored byte
//   reg_wr_data  stored byte
//   dbg_addr     side read address
//   dbg_data     register contents at dbg_addr, or 8'hFF when out of range
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module dvi_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h76,
  parameter int         NREGS    = 64
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCL,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic       busy,
  output logic       reg_wr_stb,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int         AW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [8:0] NREGS9 = 9'(NREGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < NREGS9;
  endfunction

  state_t     state;
  logic [7:0] regs [NREGS];
  logic [7:0] ptr;
  logic [7:0] sh;
  logic [3:0] cnt;
  logic       rw;
  logic       ack_phase;   // 0: ACK not yet driven, 1: ACK on the bus

  // Input synchronizers: _p0/_p1 form the 2-FF synchronizer; _p2 is the history flop
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // The bus idles high, so reset to 1 to avoid false edges after reset
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= SCL;    scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= SDA_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  // Edge and bus-event decode on synchronized signals
  logic scl_rise, scl_fall, scl_hi, sda_bit, start_det, stop_det;
  logic [7:0] wbyte, rd_data;

  assign scl_rise  =  scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 &  scl_p2;
  assign scl_hi    =  scl_p1 &  scl_p2;
  assign sda_bit   =  sda_p1;
  // SCL must be high and stable, so START/STOP can never coincide with an SCL edge
  assign start_det = ~sda_p1 &  sda_p2 & scl_hi;
  assign stop_det  =  sda_p1 & ~sda_p2 & scl_hi;

  assign wbyte   = {sh[6:0], sda_bit};
  assign rd_data = in_range(ptr) ? regs[ptr[AW-1:0]] : 8'hFF;

  assign dbg_data = in_range(dbg_addr) ? regs[dbg_addr[AW-1:0]] : 8'hFF;

  // Protocol FSM and register file
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      SDA_oe      <= 1'b0;
      busy        <= 1'b0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= 8'h00;
      reg_wr_data <= 8'h00;
      ptr         <= 8'h00;
      sh          <= 8'h00;
      cnt         <= 4'd0;
      rw          <= 1'b0;
      ack_phase   <= 1'b0;
      regs        <= '{default: 8'h00};
    end else begin
      reg_wr_stb <= 1'b0;
      if (stop_det) begin
        state     <= IDLE;
        busy      <= 1'b0;
        SDA_oe    <= 1'b0;
        cnt       <= 4'd0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        // Covers both a fresh START and a repeated START; the pointer is kept
        state     <= ADDR;
        busy      <= 1'b1;
        SDA_oe    <= 1'b0;
        cnt       <= 4'd0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sh  <= wbyte;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              rw        <= sda_bit;
              ack_phase <= 1'b0;
              state     <= (sh[6:0] == DEV_ADDR) ? ADDR_ACK : IGNORE;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              SDA_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              cnt       <= 4'd0;
              if (rw) begin
                // The MSB of the read byte goes out on the same fall that ends the ACK
                sh     <= rd_data;
                SDA_oe <= ~rd_data[7];
                state  <= RDATA;
              end else begin
                SDA_oe <= 1'b0;
                state  <= REG;
              end
            end
          end
          REG: if (scl_rise) begin
            sh  <= wbyte;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              ptr       <= wbyte;
              ack_phase <= 1'b0;
              state     <= REG_ACK;
            end
          end
          REG_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              SDA_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              SDA_oe    <= 1'b0;
              ack_phase <= 1'b0;
              cnt       <= 4'd0;
              state     <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            sh  <= wbyte;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (in_range(ptr)) begin
                regs[ptr[AW-1:0]] <= wbyte;
                reg_wr_stb        <= 1'b1;
                reg_wr_addr       <= ptr;
                reg_wr_data       <= wbyte;
              end
              ack_phase <= 1'b0;
              state     <= WDATA_ACK;
            end
          end
          WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              SDA_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              SDA_oe    <= 1'b0;
              ack_phase <= 1'b0;
              ptr       <= ptr + 8'd1;
              cnt       <= 4'd0;
              state     <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                SDA_oe <= 1'b0;
                state  <= RACK;
              end else begin
                // Shift left so that the next bit always sits in sh[6]
                sh     <= {sh[6:0], 1'b0};
                SDA_oe <= ~sh[6];
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              ptr <= ptr + 8'd1;
              if (sda_bit) state     <= IGNORE;
              else         ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              sh        <= rd_data;
              SDA_oe    <= ~rd_data[7];
              cnt       <= 4'd0;
              state     <= RDATA;
            end
          end
          IGNORE: SDA_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
